// File: rtl/event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : event_arbiter_if
// Description : Stream bundle for the event arbiter: three single-beat input
//               streams and one output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface event_arbiter_if #(
    parameter int DW = 256
);
    logic [DW-1:0] AXIS_IN0_TDATA;
    logic          AXIS_IN0_TVALID;
    logic          AXIS_IN0_TREADY;
    logic [DW-1:0] AXIS_IN1_TDATA;
    logic          AXIS_IN1_TVALID;
    logic          AXIS_IN1_TREADY;
    logic [DW-1:0] AXIS_IN2_TDATA;
    logic          AXIS_IN2_TVALID;
    logic          AXIS_IN2_TREADY;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic          AXIS_OUT_TVALID;
    logic          AXIS_OUT_TREADY;

    // Arbiter side
    modport slave (
        input  AXIS_IN0_TDATA, AXIS_IN0_TVALID,
        input  AXIS_IN1_TDATA, AXIS_IN1_TVALID,
        input  AXIS_IN2_TDATA, AXIS_IN2_TVALID,
        output AXIS_IN0_TREADY, AXIS_IN1_TREADY, AXIS_IN2_TREADY,
        output AXIS_OUT_TDATA, AXIS_OUT_TVALID,
        input  AXIS_OUT_TREADY
    );

    // Requester / downstream side
    modport master (
        output AXIS_IN0_TDATA, AXIS_IN0_TVALID,
        output AXIS_IN1_TDATA, AXIS_IN1_TVALID,
        output AXIS_IN2_TDATA, AXIS_IN2_TVALID,
        input  AXIS_IN0_TREADY, AXIS_IN1_TREADY, AXIS_IN2_TREADY,
        input  AXIS_OUT_TDATA, AXIS_OUT_TVALID,
        output AXIS_OUT_TREADY
    );
endinterface
`default_nettype wire

// File: rtl/event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : event_arbiter
// Description : Three-way round-robin arbiter for single-beat event messages
//               with a registered output beat, optional idle gap between
//               beats and saturating per-requester message counters.
// Revision    : 1.0 - initial release
// ============================================================================
module event_arbiter #(
    parameter int DW      = 256,
    parameter int MIN_GAP = 0
) (
    input  logic        clk,
    input  logic        resetn,
    event_arbiter_if.slave axis,
    output logic [1:0]  last_grant,
    output logic [15:0] msg_count0,
    output logic [15:0] msg_count1,
    output logic [15:0] msg_count2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0]  C_GAP_LOAD = 8'(MIN_GAP);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    last_grant_q, last_grant_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic [15:0]   cnt_q [3];
    logic [15:0]   cnt_d [3];

    logic [2:0]    in_valid;
    logic [2:0]    grant;
    logic [2:0]    in_ready;
    logic [1:0]    win_idx;
    logic [DW-1:0] in_data [3];

    assign in_valid   = {axis.AXIS_IN2_TVALID, axis.AXIS_IN1_TVALID, axis.AXIS_IN0_TVALID};
    assign in_data[0] = axis.AXIS_IN0_TDATA;
    assign in_data[1] = axis.AXIS_IN1_TDATA;
    assign in_data[2] = axis.AXIS_IN2_TDATA;

    // Index of the k-th candidate in the search that starts after last_grant
    function automatic logic [1:0] rr_index(input logic [1:0] last, input int k);
        int s;
        s = (int'(last) + 1 + k) % 3;
        return 2'(s);
    endfunction

    // Round-robin pick: first valid requester after the previous winner
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant   = 3'b000;
        win_idx = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx = rr_index(last_grant_q, k);
            if (!found && in_valid[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // Ready only while idle and out of reset; acceptance is ready & valid
    assign in_ready = (resetn && (state_q == IDLE)) ? grant : 3'b000;

    assign axis.AXIS_IN0_TREADY = in_ready[0];
    assign axis.AXIS_IN1_TREADY = in_ready[1];
    assign axis.AXIS_IN2_TREADY = in_ready[2];

    // Next-state: accept in IDLE, hold beat in SEND, count down in GAP
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        case (state_q)
            IDLE: begin
                if (|in_ready) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = in_data[win_idx];
                    last_grant_d = win_idx;
                    if (cnt_q[win_idx] != C_CNT_MAX) begin
                        cnt_d[win_idx] = cnt_q[win_idx] + 16'd1;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                if (axis.AXIS_OUT_TREADY) begin
                    out_valid_d = 1'b0;
                    if (MIN_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = C_GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = 8'd0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= 2'd2;
            gap_cnt_q    <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign axis.AXIS_OUT_TVALID = out_valid_q;
    assign axis.AXIS_OUT_TDATA  = out_data_q;
    assign last_grant           = last_grant_q;
    assign msg_count0           = cnt_q[0];
    assign msg_count1           = cnt_q[1];
    assign msg_count2           = cnt_q[2];

endmodule
`default_nettype wire

// File: tb/tb_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_arbiter
// Description : Self-checking bench. Two arbiters (MIN_GAP 0 and 3) receive
//               identical stimulus and are compared every cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_arbiter;

    localparam int DW = 64;

    logic clk;
    logic resetn;

    event_arbiter_if #(.DW(DW)) if0 ();
    event_arbiter_if #(.DW(DW)) if1 ();

    logic [1:0]  lg [2];
    logic [15:0] mc [2][3];

    event_arbiter #(.DW(DW), .MIN_GAP(0)) u_dut0 (
        .clk        (clk),
        .resetn     (resetn),
        .axis       (if0),
        .last_grant (lg[0]),
        .msg_count0 (mc[0][0]),
        .msg_count1 (mc[0][1]),
        .msg_count2 (mc[0][2])
    );

    event_arbiter #(.DW(DW), .MIN_GAP(3)) u_dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .axis       (if1),
        .last_grant (lg[1]),
        .msg_count0 (mc[1][0]),
        .msg_count1 (mc[1][1]),
        .msg_count2 (mc[1][2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Stimulus data presented on the three inputs
    logic [DW-1:0] din [3];

    // Reference model: per instance, is a beat outstanding, its data,
    // idle gap cycles still owed, last winner, accepted-message counts
    bit            m_pend [2];
    logic [DW-1:0] m_data [2];
    int            m_gap  [2];
    int            m_last [2];
    int            m_cnt  [2][3];

    // Logs for directed checks
    int grant0_log [$];
    int acc1_cyc   [$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_data[i] = '0;
            m_gap[i]  = 0;
            m_last[i] = 2;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare every output
    // with the model, then advance the model by the coming rising edge.
    task automatic drive_cycle(input logic rn, input logic [2:0] v, input logic ot);
        logic [2:0]    act_rdy;
        logic          act_vld;
        logic [DW-1:0] act_dat;
        logic [2:0]    exp_rdy;
        int            w;
        int            p;
        @(negedge clk);
        resetn = rn;
        if0.AXIS_IN0_TDATA = din[0]; if1.AXIS_IN0_TDATA = din[0];
        if0.AXIS_IN1_TDATA = din[1]; if1.AXIS_IN1_TDATA = din[1];
        if0.AXIS_IN2_TDATA = din[2]; if1.AXIS_IN2_TDATA = din[2];
        if0.AXIS_IN0_TVALID = v[0];  if1.AXIS_IN0_TVALID = v[0];
        if0.AXIS_IN1_TVALID = v[1];  if1.AXIS_IN1_TVALID = v[1];
        if0.AXIS_IN2_TVALID = v[2];  if1.AXIS_IN2_TVALID = v[2];
        if0.AXIS_OUT_TREADY = ot;    if1.AXIS_OUT_TREADY = ot;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                act_rdy = {if0.AXIS_IN2_TREADY, if0.AXIS_IN1_TREADY, if0.AXIS_IN0_TREADY};
                act_vld = if0.AXIS_OUT_TVALID;
                act_dat = if0.AXIS_OUT_TDATA;
            end else begin
                act_rdy = {if1.AXIS_IN2_TREADY, if1.AXIS_IN1_TREADY, if1.AXIS_IN0_TREADY};
                act_vld = if1.AXIS_OUT_TVALID;
                act_dat = if1.AXIS_OUT_TDATA;
            end
            // Winner: first valid requester searching on from the last winner
            w = -1;
            if (rn && !m_pend[i] && m_gap[i] == 0) begin
                for (int k = 0; k < 3; k++) begin
                    p = (m_last[i] + 1 + k) % 3;
                    if (w < 0 && v[p]) w = p;
                end
            end
            exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
            check_val($sformatf("d%0d_tready c%0d", i, cyc), 64'(act_rdy), 64'(exp_rdy));
            check_val($sformatf("d%0d_tvalid c%0d", i, cyc), 64'(act_vld), 64'(m_pend[i]));
            check_val($sformatf("d%0d_tdata c%0d", i, cyc), act_dat, m_data[i]);
            check_val($sformatf("d%0d_last_grant c%0d", i, cyc), 64'(lg[i]), 64'(m_last[i]));
            for (int k = 0; k < 3; k++)
                check_val($sformatf("d%0d_count%0d c%0d", i, k, cyc), 64'(mc[i][k]), 64'(m_cnt[i][k]));
            if (i == 0 && act_rdy != 3'b000) grant0_log.push_back((act_rdy == 3'b001) ? 0 : (act_rdy == 3'b010) ? 1 : 2);
            if (i == 1 && act_rdy[0]) acc1_cyc.push_back(cyc);
            // Advance the model across the rising edge
            if (!rn) begin
                m_pend[i] = 1'b0; m_data[i] = '0; m_gap[i] = 0; m_last[i] = 2;
                for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
            end else if (w >= 0) begin
                m_pend[i] = 1'b1;
                m_data[i] = din[w];
                m_last[i] = w;
                if (m_cnt[i][w] < 65535) m_cnt[i][w]++;
            end else if (m_pend[i] && ot) begin
                m_pend[i] = 1'b0;
                m_gap[i]  = gap_of(i);
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int j = 0; j < n; j++) drive_cycle(1'b0, 3'b000, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [2:0]    rv;
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) din[k] = '0;
        model_reset();

        // Reset state
        do_reset(3);
        drive_cycle(1'b1, 3'b000, 1'b1);
        check_val("rst_last_grant", 64'(lg[0]), 64'd2);
        check_val("rst_tvalid", 64'(if0.AXIS_OUT_TVALID), 64'd0);
        check_val("rst_tdata", if0.AXIS_OUT_TDATA, 64'd0);

        // Single requester 1
        do_reset(1);
        din[1] = 64'h01AA;
        drive_cycle(1'b1, 3'b010, 1'b1);
        check_val("in1_tready_same_cycle", 64'(if0.AXIS_IN1_TREADY), 64'd1);
        din[1] = 64'hDEAD;
        drive_cycle(1'b1, 3'b000, 1'b1);
        check_val("in1_out_tvalid", 64'(if0.AXIS_OUT_TVALID), 64'd1);
        check_val("in1_out_tdata", if0.AXIS_OUT_TDATA, 64'h01AA);
        check_val("in1_last_grant", 64'(lg[0]), 64'd1);
        check_val("in1_count1", 64'(mc[0][1]), 64'd1);

        // All three requesting continuously: order 0,1,2,0,1,2
        do_reset(1);
        grant0_log.delete();
        for (int j = 0; j < 12; j++) begin
            for (int k = 0; k < 3; k++) din[k] = {$urandom, $urandom};
            drive_cycle(1'b1, 3'b111, 1'b1);
        end
        check_val("rr_num_grants", 64'(grant0_log.size()), 64'd6);
        for (int j = 0; j < 6 && j < grant0_log.size(); j++)
            check_val($sformatf("rr_order_%0d", j), 64'(grant0_log[j]), 64'(j % 3));
        for (int k = 0; k < 3; k++)
            check_val($sformatf("rr_count%0d", k), 64'(mc[0][k]), 64'd2);

        // Backpressure: beat held for 10 cycles, nothing accepted
        do_reset(1);
        din[0] = 64'h1234_5678_9ABC_DEF0;
        drive_cycle(1'b1, 3'b001, 1'b0);
        held = din[0];
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 3; k++) din[k] = {$urandom, $urandom};
            drive_cycle(1'b1, 3'b111, 1'b0);
            check_val("bp_tvalid", 64'(if0.AXIS_OUT_TVALID), 64'd1);
            check_val("bp_tdata", if0.AXIS_OUT_TDATA, held);
            check_val("bp_tready", 64'({if0.AXIS_IN2_TREADY, if0.AXIS_IN1_TREADY, if0.AXIS_IN0_TREADY}), 64'd0);
        end

        // MIN_GAP=3 instance: accepts 5 cycles apart
        do_reset(1);
        acc1_cyc.delete();
        for (int j = 0; j < 22; j++) begin
            din[0] = {$urandom, $urandom};
            drive_cycle(1'b1, 3'b001, 1'b1);
        end
        check_val("gap_num_accepts", 64'(acc1_cyc.size()), 64'd5);
        for (int j = 1; j < acc1_cyc.size(); j++)
            check_val($sformatf("gap_spacing_%0d", j), 64'(acc1_cyc[j] - acc1_cyc[j-1]), 64'd5);

        // Reset pulse while a beat is pending
        do_reset(1);
        din[1] = 64'h55;
        drive_cycle(1'b1, 3'b010, 1'b0);
        drive_cycle(1'b1, 3'b000, 1'b0);
        check_val("rp_pending", 64'(if0.AXIS_OUT_TVALID), 64'd1);
        drive_cycle(1'b0, 3'b101, 1'b0);
        drive_cycle(1'b1, 3'b101, 1'b1);
        check_val("rp_tvalid", 64'(if0.AXIS_OUT_TVALID), 64'd0);
        check_val("rp_last_grant", 64'(lg[0]), 64'd2);
        check_val("rp_count1", 64'(mc[0][1]), 64'd0);
        check_val("rp_in0_first", 64'({if0.AXIS_IN2_TREADY, if0.AXIS_IN0_TREADY}), 64'b01);

        // Randomized traffic with occasional resets
        for (int j = 0; j < 3000; j++) begin
            for (int k = 0; k < 3; k++) din[k] = {$urandom, $urandom};
            rv = 3'($urandom);
            drive_cycle(($urandom_range(0, 59) != 0), rv, ($urandom_range(0, 9) < 7));
        end

        // Counter saturation: requester 2 streams past 65535 messages
        do_reset(1);
        for (int j = 0; j < 2 * 65540 + 4; j++) begin
            din[2] = 64'(j);
            drive_cycle(1'b1, 3'b100, 1'b1);
        end
        check_val("sat_count2", 64'(mc[0][2]), 64'hFFFF);
        check_val("sat_count0", 64'(mc[0][0]), 64'd0);
        check_val("sat_count1", 64'(mc[0][1]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
